dram_ctrl: RTL

DRAM_CTRL -- requirements
Module: dram_ctrl

---
 rtl/dram_pkg.sv | 11 +
 rtl/dram_refresh_timer.sv | 37 +++
 rtl/dram_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: state encoding and default parameters shared by the DRAM controller files.
package dram_pkg;
  typedef enum logic [2:0] {IDLE, ROW, COL, HOLD, PRE, RCAS, RRAS, RPRE} state_t;
  localparam int ROW_W_DEF = 12;
  localparam int COL_W_DEF = 10;
  localparam int BANKS_DEF = 2;
  localparam int TRCD_DEF = 1;
  localparam int TRP_DEF = 2;
  localparam int REF_PERIOD_DEF = 250;
  localparam int CNT_W = 8;
endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: periodic refresh request generator, built only with DRAM_INTREF_EN.
// Pending refreshes saturate at two; the second one escalates to an urgent request.
`ifdef DRAM_INTREF_EN
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic CLK,
  input  logic Reset,
  input  logic ref_start,
  output logic ref_req,
  output logic ref_urg
);
  localparam int TW = $clog2(REF_PERIOD + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0] pend_q, pend_d;
  logic tick, dec;
  always_comb begin
    tick = tmr_q == TW'(REF_PERIOD - 1);
    dec = ref_start & (pend_q != 2'd0);
    tmr_d = tick ? '0 : tmr_q + 1'b1;
    pend_d = (pend_q == 2'd2 && tick && !dec) ? 2'd2 : pend_q + {1'b0, tick} - {1'b0, dec};
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      tmr_q <= '0;
      pend_q <= '0;
    end else begin
      tmr_q <= tmr_d;
      pend_q <= pend_d;
    end
  end
  assign ref_req = pend_q != 2'd0;
  assign ref_urg = pend_q == 2'd2;
endmodule
`endif

// File: rtl/dram_ctrl.sv
// dram_ctrl: 68000 bus to asynchronous DRAM controller with CAS-before-RAS refresh.
// Define DRAM_INTREF_EN to replace the RefReq/RefUrgent inputs with an internal refresh timer.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int BANKS = BANKS_DEF,
  parameter int TRCD = TRCD_DEF,
  parameter int TRP = TRP_DEF,
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  localparam int BW = $clog2(BANKS),
  localparam int AW = ROW_W + COL_W + BW
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [AW:1]      A,
  input  logic             nWE,
  input  logic             nAS,
  input  logic             nLDS,
  input  logic             nUDS,
  input  logic             ASActive,
  input  logic             ASInactive,
  input  logic             RAMCS,
  input  logic             RefReq,
  input  logic             RefUrgent,
  output logic             Ready,
  output logic             RefAck,
  output logic [ROW_W-1:0] RA,
  output logic [BANKS-1:0] nRAS,
  output logic             nLCAS,
  output logic             nUCAS,
  output logic             nDWE
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic once_q, once_d;
  logic [AW:1] addr_q, addr_d;
  logic [2:0] strb_q, strb_d;
  logic ref_req, ref_urg, bus_req, cnt_done, in_acc, in_cas;
  logic [BW-1:0] bank;
  logic [ROW_W-1:0] row, col;
  logic unused_nas;
  assign unused_nas = nAS;
`ifdef DRAM_INTREF_EN
  logic ref_start, unused_ref;
  assign unused_ref = RefReq ^ RefUrgent;
  assign ref_start = (state_q == IDLE) && (state_d == RCAS);
  dram_refresh_timer #(.REF_PERIOD(REF_PERIOD)) u_timer (
    .CLK(CLK),
    .Reset(Reset),
    .ref_start(ref_start),
    .ref_req(ref_req),
    .ref_urg(ref_urg)
  );
`else
  assign ref_req = RefReq;
  assign ref_urg = RefUrgent;
`endif
  assign bus_req = ASActive & RAMCS;
  assign cnt_done = cnt_q == '0;
  assign bank = addr_q[AW:ROW_W+COL_W+1];
  assign row = addr_q[ROW_W+COL_W:COL_W+1];
  assign col = ROW_W'(addr_q[COL_W:1]);
  // Timed states load cnt with their length minus one and leave when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_done ? cnt_q : cnt_q - 1'b1;
    once_d = once_q & ~ASInactive;
    addr_d = addr_q;
    strb_d = strb_q;
    case (state_q)
      IDLE:
        if (ref_urg) state_d = RCAS;
        else if (bus_req & ~once_q) begin
          state_d = ROW;
          cnt_d = CNT_W'(TRCD - 1);
          once_d = 1'b1;
          addr_d = A;
        end else if (ref_req & ~bus_req) state_d = RCAS;
      ROW: state_d = cnt_done ? COL : ROW;
      COL: begin
        state_d = HOLD;
        strb_d = {nUDS, nLDS, nWE};
      end
      HOLD:
        if (ASInactive) begin
          state_d = PRE;
          cnt_d = CNT_W'(TRP - 1);
        end
      PRE: state_d = cnt_done ? IDLE : PRE;
      RCAS: begin
        state_d = RRAS;
        cnt_d = CNT_W'(1);
      end
      RRAS:
        if (cnt_done) begin
          state_d = RPRE;
          cnt_d = CNT_W'(TRP - 1);
        end
      RPRE: state_d = cnt_done ? IDLE : RPRE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      once_q <= 1'b0;
      addr_q <= '0;
      strb_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      once_q <= once_d;
      addr_q <= addr_d;
      strb_q <= strb_d;
    end
  end
  // HOLD replays the byte strobes and write enable sampled during COL.
  assign in_acc = state_q inside {ROW, COL, HOLD};
  assign in_cas = state_q inside {RCAS, RRAS};
  assign RA = (state_q == ROW) ? row : (state_q inside {COL, HOLD}) ? col : '0;
  assign nRAS = (state_q == RRAS) ? '0 : in_acc ? ~(BANKS'(1) << bank) : '1;
  assign nLCAS = (state_q == COL) ? nLDS : (state_q == HOLD) ? strb_q[1] : ~in_cas;
  assign nUCAS = (state_q == COL) ? nUDS : (state_q == HOLD) ? strb_q[2] : ~in_cas;
  assign nDWE = (state_q == COL) ? nWE : (state_q == HOLD) ? strb_q[0] : 1'b1;
  assign RefAck = state_q inside {RCAS, RRAS, RPRE};
  assign Ready = ~RAMCS | (state_q inside {COL, HOLD});
endmodule
